atm_session_arbiter: RTL
========================

Name: atm_session_arbiter

Overview:
- Front-end controller that shares one ATM core between N_REQ terminal requesters.
- Grants requesters round-robin and latches the winner's command.
- Sequences the core: a one-cycle core reset, then the command held stable for CORE_CYCLES cycles.
- Captures balance/success, returns a tagged one-cycle response, and enforces per-account PIN lockout after MAX_TRIES consecutive failures.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- CORE_CYCLES, 4, cycles the command is held on the core before sampling.
- MAX_TRIES, 3, consecutive failed transactions that lock an account.
- NUM_ACC, 10, accounts 1..NUM_ACC are tracked for lockout.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester request, held until its gnt bit.
- req_operation  in  3*N_REQ  operation code, slice i for requester i.
- req_acc_num  in  4*N_REQ  account number.
- req_pin  in  16*N_REQ  PIN.
- req_newpin  in  16*N_REQ  new PIN for change-PIN.
- req_amount  in  32*N_REQ  amount.
- req_language  in  N_REQ  language select.
- unlock_valid  in  1  admin unlock strobe.
- unlock_acc  in  4  account to unlock.
- gnt  out  N_REQ  one-hot grant, one-cycle pulse.
- rsp_valid  out  1  response pulse.
- rsp_id  out  3  index of the served requester.
- rsp_success  out  1  transaction success.
- rsp_balance  out  32  balance sampled from the core.
- rsp_locked  out  1  account lock status after this transaction.
- core_rst_n  out  1  active-low reset to the ATM core.
- core_operation, core_acc_num, core_pin, core_newpin, core_amount, core_language  out  3/4/16/16/32/1  latched command to the core.
- core_balance  in  32  core balance.
- core_success  in  1  core success.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, rr pointer=0.
  - All fail counters=0; all lock bits cleared.
  - gnt=0, rsp_valid=0, rsp_* = 0, core_* command = 0, core_rst_n=0.
  - Reset during any state aborts the transaction; no rsp_valid is produced.
- State machine: IDLE, LOAD, RUN, RESP.
- IDLE:
  - core_rst_n=1.
  - If req != 0, select the first set bit searching ptr, ptr+1, ... with wrap modulo N_REQ.
  - Latch all fields of the winner into the command registers.
  - Tracked account (1..NUM_ACC) that is locked: next state RESP with gnt[i]=1 and rsp_valid=1 in the same cycle; rsp_success=0, rsp_locked=1, rsp_balance=0; core untouched.
  - Otherwise: next state LOAD.
- LOAD (1 cycle):
  - gnt[i]=1, core_rst_n=0, latched command on core_*.
  - Next state RUN; counter=CORE_CYCLES-1.
- RUN (CORE_CYCLES cycles):
  - core_rst_n=1; command held stable.
  - In the last cycle, register core_success and core_balance.
  - Next state RESP.
- RESP (1 cycle):
  - rsp_valid=1, rsp_id=i.
  - Fail counter update for tracked accounts:
    - success=1 clears the counter.
    - success=0 increments it, saturating at MAX_TRIES.
    - Reaching MAX_TRIES sets the lock bit.
  - rsp_locked shows the post-update lock bit.
  - ptr=(i+1) mod N_REQ.
  - Next state IDLE.
- Latency:
  - Normal path: gnt cycle k (LOAD), rsp_valid at k+1+CORE_CYCLES.
  - Locked path: gnt and rsp_valid in the same cycle.
  - Minimum gap between grants is one IDLE cycle.
- Request handling:
  - Requests arriving during a transaction wait.
  - A req deasserted before grant is never served.
  - Inputs after gnt are ignored.
- Untracked accounts (0, >NUM_ACC): forwarded to the core; no lock logic; rsp_locked=0.
- Unlock: unlock_valid clears the counter and lock bit of unlock_acc in any state. If it coincides with a RESP update to the same account, unlock wins.
- Width rules: rsp_balance is passed unchanged; no arithmetic on amounts.

Test Plan:
- Reset hold: rst=1 for 3 cycles with req=2'b11 -> gnt=0, rsp_valid=0, core_rst_n=0 throughout.
- Single request: req0 op=3, acc=1, pin=1234 -> gnt=2'b01 at cycle k, core_rst_n=0 at k only, rsp_valid at k+5, rsp_id=0, rsp_success=core_success, rsp_balance=core_balance.
- Round-robin fairness: req=2'b11 held continuously -> grants alternate 01,10,01,10. A second pass with ptr=1 at start -> first grant is 10.
- Lockout: three transactions on acc 2 with pin 9999 (core_success=0) -> third rsp_locked=1. Fourth request with pin 2345 -> gnt and rsp_valid in the same cycle, rsp_success=0, rsp_locked=1, core_rst_n stays 1.
- Unlock and counter clear:
  - unlock_valid with acc=2 in the same cycle as a failing RESP on acc 2 -> lock bit 0, counter 0.
  - A subsequent correct-PIN deposit of 1000 -> rsp_success=1, rsp_balance = prior balance + 1000.
- Reset mid-RUN: assert rst in the 2nd RUN cycle -> no rsp_valid, state IDLE, locks cleared, next req served normally.

Source files
------------

// File: rtl/atm_session_arbiter_if.sv
// Requester-side bus of the ATM session arbiter.
// Carries the per-requester command fields (packed, slice i belongs to
// requester i), the one-hot grant and the tagged response.
//   slave  : arbiter side (command in, grant/response out)
//   master : requester side (command out, grant/response in)
interface atm_session_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]    req;
    logic [3*N_REQ-1:0]  req_operation;
    logic [4*N_REQ-1:0]  req_acc_num;
    logic [16*N_REQ-1:0] req_pin;
    logic [16*N_REQ-1:0] req_newpin;
    logic [32*N_REQ-1:0] req_amount;
    logic [N_REQ-1:0]    req_language;
    logic [N_REQ-1:0]    gnt;
    logic                rsp_valid;
    logic [2:0]          rsp_id;
    logic                rsp_success;
    logic [31:0]         rsp_balance;
    logic                rsp_locked;

    modport slave (
        input  req, req_operation, req_acc_num, req_pin, req_newpin,
               req_amount, req_language,
        output gnt, rsp_valid, rsp_id, rsp_success, rsp_balance, rsp_locked
    );

    modport master (
        output req, req_operation, req_acc_num, req_pin, req_newpin,
               req_amount, req_language,
        input  gnt, rsp_valid, rsp_id, rsp_success, rsp_balance, rsp_locked
    );
endinterface

// File: rtl/atm_session_arbiter.sv
// Shares one ATM core between N_REQ requesters. Round-robin grant, latches
// the winner's command, pulses the core reset for one cycle, holds the
// command for CORE_CYCLES cycles, samples the result and returns a tagged
// one-cycle response. Tracks consecutive failures per account (1..NUM_ACC)
// and locks an account after MAX_TRIES of them; locked accounts are answered
// immediately without touching the core.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bus (slave)              requests, grant, response
//   unlock_valid/unlock_acc  admin unlock of one account
//   core_*                   command to / result from the ATM core
//
// state | meaning
// IDLE  | core out of reset, pick next requester
// LOAD  | grant pulse, core held in reset, command presented
// RUN   | command held on core, result sampled in the last cycle
// RESP  | response pulse, advance round-robin pointer
module atm_session_arbiter #(
    parameter int N_REQ       = 2,
    parameter int CORE_CYCLES = 4,
    parameter int MAX_TRIES   = 3,
    parameter int NUM_ACC     = 10
) (
    input  logic                clk,
    input  logic                rst,
    atm_session_arbiter_if.slave bus,
    input  logic                unlock_valid,
    input  logic [3:0]          unlock_acc,
    output logic                core_rst_n,
    output logic [2:0]          core_operation,
    output logic [3:0]          core_acc_num,
    output logic [15:0]         core_pin,
    output logic [15:0]         core_newpin,
    output logic [31:0]         core_amount,
    output logic                core_language,
    input  logic [31:0]         core_balance,
    input  logic                core_success
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = (CORE_CYCLES > 1) ? $clog2(CORE_CYCLES) : 1;
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam logic [FW-1:0] MAX_F    = FW'(MAX_TRIES);
    localparam logic [3:0]    LAST_ACC = 4'(NUM_ACC);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t           state_q;
    logic [PW-1:0]    ptr_q, sel_q;
    logic [CW-1:0]    cnt_q;
    logic [N_REQ-1:0] gnt_q;
    logic             rsp_valid_q, rsp_success_q, rsp_locked_q;
    logic [2:0]       rsp_id_q;
    logic [31:0]      rsp_balance_q;
    logic             core_rst_n_q;
    logic [2:0]       op_q;
    logic [3:0]       acc_q;
    logic [15:0]      pin_q, newpin_q;
    logic [31:0]      amount_q;
    logic             lang_q;
    logic [15:0]      lock_q;
    logic [FW-1:0]    fail_q [16];

    function automatic logic tracked(input logic [3:0] a);
        return (a != 4'd0) && (a <= LAST_ACC);
    endfunction

    // Round-robin search starting at ptr_q, wrapping modulo N_REQ.
    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [PW:0]   scan;
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(N_REQ)) scan = scan - (PW+1)'(N_REQ);
            if (!win_found && bus.req[scan[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[PW-1:0];
            end
        end
    end

    logic [2:0]  win_op;
    logic [3:0]  win_acc;
    logic [15:0] win_pin, win_newpin;
    logic [31:0] win_amount;
    logic        win_lang;
    always_comb begin
        win_op     = '0;
        win_acc    = '0;
        win_pin    = '0;
        win_newpin = '0;
        win_amount = '0;
        win_lang   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == PW'(k)) begin
                win_op     = bus.req_operation[3*k +: 3];
                win_acc    = bus.req_acc_num[4*k +: 4];
                win_pin    = bus.req_pin[16*k +: 16];
                win_newpin = bus.req_newpin[16*k +: 16];
                win_amount = bus.req_amount[32*k +: 32];
                win_lang   = bus.req_language[k];
            end
        end
    end

    logic win_locked;
    assign win_locked = win_found && tracked(win_acc) && lock_q[win_acc];

    // Lockout bookkeeping happens on the edge that enters RESP so that
    // rsp_locked can already show the post-update lock bit.
    logic       upd_en, upd_fail, upd_trk, unl_hit, upd_locked;
    logic [3:0] upd_acc;
    always_comb begin
        upd_en   = 1'b0;
        upd_acc  = acc_q;
        upd_fail = !core_success;
        if (state_q == IDLE && win_locked) begin
            upd_en   = 1'b1;
            upd_acc  = win_acc;
            upd_fail = 1'b1;
        end else if (state_q == RUN && cnt_q == '0) begin
            upd_en = 1'b1;
        end
        upd_trk    = tracked(upd_acc);
        unl_hit    = unlock_valid && (unlock_acc == upd_acc);
        upd_locked = upd_trk && !unl_hit &&
                     (lock_q[upd_acc] || (upd_fail && fail_q[upd_acc] >= MAX_F - FW'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            sel_q         <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_success_q <= 1'b0;
            rsp_locked_q  <= 1'b0;
            rsp_id_q      <= '0;
            rsp_balance_q <= '0;
            core_rst_n_q  <= 1'b0;
            op_q          <= '0;
            acc_q         <= '0;
            pin_q         <= '0;
            newpin_q      <= '0;
            amount_q      <= '0;
            lang_q        <= 1'b0;
            lock_q        <= '0;
            for (int a = 0; a < 16; a++) fail_q[a] <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    core_rst_n_q <= 1'b1;
                    if (win_found) begin
                        sel_q    <= win_idx;
                        op_q     <= win_op;
                        acc_q    <= win_acc;
                        pin_q    <= win_pin;
                        newpin_q <= win_newpin;
                        amount_q <= win_amount;
                        lang_q   <= win_lang;
                        gnt_q    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        if (win_locked) begin
                            rsp_valid_q   <= 1'b1;
                            rsp_id_q      <= 3'(win_idx);
                            rsp_success_q <= 1'b0;
                            rsp_balance_q <= '0;
                            rsp_locked_q  <= 1'b1;
                            state_q       <= RESP;
                        end else begin
                            core_rst_n_q <= 1'b0;
                            state_q      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    core_rst_n_q <= 1'b1;
                    cnt_q        <= CW'(CORE_CYCLES - 1);
                    state_q      <= RUN;
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_id_q      <= 3'(sel_q);
                        rsp_success_q <= core_success;
                        rsp_balance_q <= core_balance;
                        rsp_locked_q  <= upd_locked;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    ptr_q   <= (sel_q == PW'(N_REQ - 1)) ? '0 : sel_q + PW'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (upd_en && upd_trk) begin
                if (!upd_fail) fail_q[upd_acc] <= '0;
                else if (fail_q[upd_acc] != MAX_F) fail_q[upd_acc] <= fail_q[upd_acc] + FW'(1);
                if (upd_locked) lock_q[upd_acc] <= 1'b1;
            end
            // Placed last so an unlock overrides a same-edge failure update.
            if (unlock_valid && tracked(unlock_acc)) begin
                fail_q[unlock_acc] <= '0;
                lock_q[unlock_acc] <= 1'b0;
            end
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_success = rsp_success_q;
    assign bus.rsp_balance = rsp_balance_q;
    assign bus.rsp_locked  = rsp_locked_q;
    assign core_rst_n      = core_rst_n_q;
    assign core_operation  = op_q;
    assign core_acc_num    = acc_q;
    assign core_pin        = pin_q;
    assign core_newpin     = newpin_q;
    assign core_amount     = amount_q;
    assign core_language   = lang_q;
endmodule
